axi_rd_master: RTL and testbench

AXI4 read initiator. Accepts a simple read command (start address, beat count) and issues one or more INCR read bursts to an AXI4 slave such as the on-chip AXI RAM. Returned data is forwarded on a valid/ready stream, and completion is reported on a one-cycle status strobe. It sits between layer-config/fetch logic and the AXI fabric.

---
 rtl/axi_rd_master.sv | 130 +++++++++++++
 tb/tb_axi_rd_master.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_master.sv
// AXI4 read initiator: splits a (start address, beat count) command into INCR bursts that never cross 4 KB.
// Optional macro AXI_RD_MASTER_ERR_ABORT_EN stops issuing bursts after the first error response.
module axi_rd_master #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 16,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int ID_WIDTH      = 8,
  parameter int AXI_ID        = 0,
  parameter int LEN_WIDTH     = 16,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sts_valid,
  output logic                  sts_error,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ADDR   = 2'd1;
  localparam logic [1:0] DATA   = 2'd2;
  localparam logic [1:0] STATUS = 2'd3;

  localparam int SIZE_LOG2 = $clog2(STRB_WIDTH);
  localparam int RW        = LEN_WIDTH + 1;
  localparam int CW        = (RW > 13) ? RW : 13;

  logic [1:0]            state;
  logic                  rst_hold;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [RW-1:0]         remaining;
  logic                  err_flag;

  logic [12:0]           page_beats;
  logic [CW-1:0]         beats;
  logic                  in_data;
  logic                  r_accept;
  logic                  burst_final;

  // Burst size is derived from registered address/remaining only, so AR fields hold while arready is low.
  always_comb begin
    page_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> SIZE_LOG2;
    beats      = CW'(MAX_BURST_LEN);
    if (CW'(remaining) < beats) beats = CW'(remaining);
    if (CW'(page_beats) < beats) beats = CW'(page_beats);
  end

`ifdef AXI_RD_MASTER_ERR_ABORT_EN
  logic err_now;
  assign err_now     = err_flag || (m_axi_rvalid && (m_axi_rresp != 2'b00));
  assign burst_final = (remaining == '0) || err_now;
`else
  assign burst_final = (remaining == '0);
`endif

  // Every channel transfers on a cycle where valid && ready; a source holds valid and payload until then.
  // R is a zero-latency pass-through to the out stream, so rready simply mirrors out_ready in DATA.
  assign in_data       = (state == DATA) && !rst;
  assign cmd_ready     = (state == IDLE) && !rst && !rst_hold;
  assign m_axi_arvalid = (state == ADDR) && !rst;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(beats - CW'(1));
  assign m_axi_arsize  = 3'(SIZE_LOG2);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arid    = ID_WIDTH'(AXI_ID);
  assign out_valid     = in_data && m_axi_rvalid;
  assign out_data      = m_axi_rdata;
  assign m_axi_rready  = in_data && out_ready;
  assign out_last      = in_data && m_axi_rlast && burst_final;
  assign r_accept      = m_axi_rvalid && m_axi_rready;
  assign sts_valid     = (state == STATUS) && !rst;
  assign sts_error     = sts_valid && err_flag;
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rst_hold  <= 1'b1;
      addr_q    <= '0;
      remaining <= '0;
      err_flag  <= 1'b0;
    end else begin
      rst_hold <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            addr_q    <= cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
            remaining <= RW'(cmd_len) + RW'(1);
            err_flag  <= 1'b0;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (m_axi_arready) begin
            addr_q    <= addr_q + (ADDR_WIDTH'(beats) << SIZE_LOG2);
            remaining <= remaining - RW'(beats);
            state     <= DATA;
          end
        end
        DATA: begin
          if (r_accept && (m_axi_rresp != 2'b00)) err_flag <= 1'b1;
          if (r_accept && m_axi_rlast) state <= burst_final ? STATUS : ADDR;
        end
        STATUS: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_master.sv
// Directed bench for axi_rd_master: behavioural AXI slave, expected-queue scoreboard, assertion checks.
`timescale 1ns/1ps
module tb_axi_rd_master;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int IW  = 8;
  localparam int LW  = 16;
  localparam int MBL = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] out_data;
  logic          out_last, out_valid, out_ready;
  logic          sts_valid, sts_error;
  logic [IW-1:0] m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [1:0]    dbg_state;

  axi_rd_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .AXI_ID(0), .LEN_WIDTH(LW), .MAX_BURST_LEN(MBL)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .sts_valid(sts_valid), .sts_error(sts_error),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int sts_cnt     = 0;
  int beat_cnt    = 0;

  logic [AW+7:0] exp_ar_q[$];
  logic [DW:0]   exp_q[$];
  logic [0:0]    exp_sts_q[$];

  int            ar_delay   = 0;
  int            rgap_en    = 0;
  int            ready_mode = 0;
  logic          err_en     = 1'b0;
  logic [AW-1:0] err_addr   = '0;

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference: split a command into bursts and push AR, beat and status expectations
  task automatic expect_cmd(input logic [AW-1:0] a_in, input logic [LW-1:0] l);
    logic [AW-1:0] a, b;
    int            rem, n, page;
    logic          err_any, burst_err, lst;
    a       = a_in & 16'hFFFC;
    rem     = int'(l) + 1;
    err_any = 1'b0;
    while (rem > 0) begin
      page = (4096 - int'(a[11:0])) / (DW / 8);
      n    = (rem < MBL) ? rem : MBL;
      if (page < n) n = page;
      exp_ar_q.push_back({a, 8'(n - 1)});
      burst_err = 1'b0;
      for (int i = 0; i < n; i++) begin
        b = a + AW'(4 * i);
        if (err_en && (b == err_addr)) burst_err = 1'b1;
      end
      err_any = err_any | burst_err;
      rem     = rem - n;
`ifdef AXI_RD_MASTER_ERR_ABORT_EN
      if (err_any) rem = 0;
`endif
      for (int i = 0; i < n; i++) begin
        b   = a + AW'(4 * i);
        lst = (i == n - 1) && (rem == 0);
        exp_q.push_back({lst, beat_data(b)});
      end
      a = a + AW'(4 * n);
    end
    exp_sts_q.push_back(err_any);
  endtask

  // driver tasks
  task automatic send_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
    int   n;
    logic hs;
    n  = 0;
    hs = 1'b0;
    expect_cmd(a, l);
    @(posedge clk); #1;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    while (!hs && n < 200) begin
      @(negedge clk);
      hs = cmd_ready;
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    check("cmd_accept", hs, 1);
  endtask

  task automatic run_cmd(input logic [AW-1:0] a, input logic [LW-1:0] l);
    int target, n;
    target = sts_cnt + 1;
    n      = 0;
    send_cmd(a, l);
    while (sts_cnt < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("sts_arrived", sts_cnt >= target, 1);
    repeat (2) @(posedge clk);
  endtask

  // behavioural AXI slave: one burst at a time, programmable AR delay, optional R gaps and error beat
  initial begin : slave
    logic          active, ar_hs, r_hs;
    logic [AW-1:0] baddr;
    logic [7:0]    blen, bidx;
    int            wait_cnt;
    active = 1'b0; baddr = '0; blen = '0; bidx = '0; wait_cnt = 0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
    forever begin
      @(negedge clk);
      ar_hs = m_axi_arvalid && m_axi_arready;
      r_hs  = m_axi_rvalid && m_axi_rready;
      if (ar_hs) begin
        baddr = m_axi_araddr;
        blen  = m_axi_arlen;
      end
      @(posedge clk); #1;
      if (rst) begin
        active = 1'b0; wait_cnt = 0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
      end else begin
        if (ar_hs) begin
          active = 1'b1; bidx = '0; wait_cnt = 0; m_axi_arready = 1'b0;
        end else if (!active && m_axi_arvalid && !m_axi_arready) begin
          if (wait_cnt >= ar_delay) m_axi_arready = 1'b1;
          else wait_cnt++;
        end
        if (r_hs) begin
          if (m_axi_rlast) active = 1'b0;
          else begin
            bidx++;
            baddr = baddr + AW'(4);
          end
          m_axi_rvalid = 1'b0;
        end
        if (active && !m_axi_rvalid) begin
          if (rgap_en == 0 || $urandom_range(0, 3) != 0) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = beat_data(baddr);
            m_axi_rlast  = (bidx == blen);
            m_axi_rresp  = (err_en && baddr == err_addr) ? 2'b10 : 2'b00;
          end
        end
      end
    end
  end

  initial begin : ready_drv
    int ph;
    ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1: begin
          out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
          ph++;
        end
        2: out_ready = ($urandom_range(0, 1) == 1);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // scoreboard / protocol monitor
  initial begin : monitor
    logic [AW+7:0] ar_e;
    logic [DW:0]   d_e;
    logic          sts_prev, ar_wait;
    logic [AW-1:0] pa;
    logic [7:0]    pl;
    sts_prev = 1'b0; ar_wait = 1'b0; pa = '0; pl = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sts_prev = 1'b0;
        ar_wait  = 1'b0;
      end else begin
        if (ar_wait) begin
          check("ar_hold_valid", m_axi_arvalid, 1);
          check("ar_hold_addr", m_axi_araddr, pa);
          check("ar_hold_len", m_axi_arlen, pl);
        end
        if (m_axi_arvalid && m_axi_arready) begin
          if (exp_ar_q.size() == 0) check("ar_unexpected", m_axi_arvalid, 0);
          else begin
            ar_e = exp_ar_q.pop_front();
            check("araddr", m_axi_araddr, ar_e[AW+7:8]);
            check("arlen", m_axi_arlen, ar_e[7:0]);
            check("arsize", m_axi_arsize, 3'd2);
            check("arburst", m_axi_arburst, 2'b01);
            check("arid", m_axi_arid, 0);
          end
        end
        ar_wait = m_axi_arvalid && !m_axi_arready;
        pa      = m_axi_araddr;
        pl      = m_axi_arlen;
        check("out_valid_pass", out_valid, m_axi_rvalid);
        if (m_axi_rvalid) check("rready_mirror", m_axi_rready, out_ready);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("out_unexpected", out_valid, 0);
          else begin
            d_e = exp_q.pop_front();
            check("out_data", out_data, d_e[DW-1:0]);
            check("out_last", out_last, d_e[DW]);
          end
          beat_cnt++;
        end
        if (sts_prev) check("sts_one_cycle", sts_valid, 0);
        else if (sts_valid) begin
          if (exp_sts_q.size() == 0) check("sts_unexpected", sts_valid, 0);
          else check("sts_error", sts_error, exp_sts_q.pop_front());
          sts_cnt++;
        end
        sts_prev = sts_valid;
      end
    end
  end

  // directed sequence
  initial begin : main
    int base, n;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    rst       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sts_valid", sts_valid, 0);
    check("rst_sts_error", sts_error, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready_c1", cmd_ready, 0);
    @(negedge clk);
    check("post_rst_cmd_ready_c2", cmd_ready, 1);

    // single short burst, multi-burst split, 4 KB crossing
    run_cmd(16'h0100, 16'd3);
    run_cmd(16'h0000, 16'd39);
    run_cmd(16'h0FF8, 16'd7);

    // back-pressure on out, slow arready
    ready_mode = 1;
    ar_delay   = 3;
    run_cmd(16'h0000, 16'd39);
    ready_mode = 0;
    ar_delay   = 0;

    // error response on beat 2 of burst 1
    err_en   = 1'b1;
    err_addr = 16'h0004;
    run_cmd(16'h0000, 16'd39);
    err_en   = 1'b0;

    // unaligned start address that wraps the address space
    run_cmd(16'hFFF3, 16'd9);

    // reset in the middle of the data phase
    base = beat_cnt;
    n    = 0;
    send_cmd(16'h0000, 16'd39);
    while (beat_cnt < base + 5 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("mid_beats_seen", beat_cnt >= base + 5, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_ar_q.delete();
    exp_q.delete();
    exp_sts_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_arvalid", m_axi_arvalid, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sts_valid", sts_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_cmd_ready_c1", cmd_ready, 0);
    @(negedge clk);
    check("midrst_cmd_ready_c2", cmd_ready, 1);
    run_cmd(16'h0200, 16'd0);

    // random commands with random back-pressure and R gaps
    ready_mode = 2;
    rgap_en    = 1;
    for (int k = 0; k < 6; k++) begin
      ar_delay = $urandom_range(0, 4);
      run_cmd(AW'($urandom_range(0, 16'hFFFF)), LW'($urandom_range(0, 40)));
    end
    ready_mode = 0;
    rgap_en    = 0;
    repeat (4) @(posedge clk);

    check("ar_queue_drained", exp_ar_q.size(), 0);
    check("data_queue_drained", exp_q.size(), 0);
    check("sts_queue_drained", exp_sts_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
